// File: rtl/sys_cmd_ctrl_pkg.sv
// sys_ctrl_pkg: shared definitions for the command sequencer.
//  - Command opcodes (first byte of a frame)
//  - Sequencer state encoding
//  - Register-file addresses used for ALU operands
//  - Helper that identifies the operand-collection states (the states the
//    optional idle timeout watches)
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;  // {addr, data}
  localparam logic [7:0] CMD_RD      = 8'hBB;  // {addr}
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;  // {A, B, fun}
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;  // {fun}

  localparam int unsigned REG0_ADDR = 0;
  localparam int unsigned REG1_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_OP_A,
    ST_OP_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_e;

  // States that are waiting on host bytes to complete a command.
  function automatic logic is_collect_state(state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_OP_A)    || (s == ST_OP_B)    || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if: bundle of the sequencer's datapath-facing signals.
//  RX       : rx_data, rx_valid
//  Reg file : rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, rf_rd_data, rf_rd_valid
//  ALU      : alu_en, alu_fun, alu_out, alu_out_valid, alu_clk_en
//  TX FIFO  : tx_data, tx_wr_en, tx_full
//  Status   : cmd_err
// Modports: master = the sequencer, slave = the surrounding datapath.
interface sys_cmd_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) ();
  logic [DATA_W-1:0]   rx_data;
  logic                rx_valid;
  logic [ADDR_W-1:0]   rf_addr;
  logic                rf_wr_en;
  logic [DATA_W-1:0]   rf_wr_data;
  logic                rf_rd_en;
  logic [DATA_W-1:0]   rf_rd_data;
  logic                rf_rd_valid;
  logic                alu_en;
  logic [3:0]          alu_fun;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_out_valid;
  logic                alu_clk_en;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_wr_en;
  logic                tx_full;
  logic                cmd_err;

  modport master (
    input  rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, alu_clk_en,
           tx_data, tx_wr_en, cmd_err
  );

  modport slave (
    output rx_data, rx_valid, rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_full,
    input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun, alu_clk_en,
           tx_data, tx_wr_en, cmd_err
  );
endinterface

// File: rtl/sys_cmd_timeout.sv
// sys_cmd_timeout: idle counter for partially received commands.
//  clk, rst  : clock, synchronous active-high reset
//  count_en  : sequencer is in an operand-collection state
//  clear     : a byte arrived this cycle (restarts the idle count)
//  expired   : counter reached TIMEOUT_CYC-1 with no byte; abort the command
module sys_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count_q;

  assign expired = count_en && !clear && (count_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !count_en || expired) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end
endmodule

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: command sequencer between the UART RX path and the datapath.
// Decodes framed commands from validated RX bytes:
//   0xAA addr data  -> register write
//   0xBB addr       -> register read, data returned as one TX byte
//   0xCC A B fun    -> A->r0, B->r1, ALU op, 16-bit result returned lo then hi
//   0xDD fun        -> ALU op on current r0/r1, result returned lo then hi
// Unknown first bytes pulse cmd_err.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : sys_cmd_ctrl_if.master (RX, reg file, ALU, TX FIFO, cmd_err)
// Build option: define CMD_TIMEOUT_EN to abort a partial command after
// TIMEOUT_CYC idle cycles (cmd_err pulse, return to IDLE).
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst,
  sys_cmd_ctrl_if.master bus
);

  state_e            state;
  logic [ADDR_W-1:0] rf_addr;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_rd_en;
  logic              alu_en;
  logic [3:0]        alu_fun;
  logic              alu_clk_en;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] result_hi;
  logic              is_read;
  logic              cmd_err;
  logic              timeout_hit;

`ifdef CMD_TIMEOUT_EN
  sys_cmd_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .count_en (is_collect_state(state)),
    .clear    (bus.rx_valid),
    .expired  (timeout_hit)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
`endif

  assign bus.rf_addr    = rf_addr;
  assign bus.rf_wr_en   = rf_wr_en;
  assign bus.rf_wr_data = rf_wr_data;
  assign bus.rf_rd_en   = rf_rd_en;
  assign bus.alu_en     = alu_en;
  assign bus.alu_fun    = alu_fun;
  assign bus.alu_clk_en = alu_clk_en;
  assign bus.tx_data    = tx_data;
  assign bus.cmd_err    = cmd_err;

  // tx_data is staged a cycle ahead; the push is qualified by the live
  // tx_full so a byte is never offered to a full FIFO.
  assign bus.tx_wr_en = ((state == ST_TX_LO) || (state == ST_TX_HI)) && !bus.tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rf_addr    <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_data <= '0;
      rf_rd_en   <= 1'b0;
      alu_en     <= 1'b0;
      alu_fun    <= '0;
      alu_clk_en <= 1'b0;
      tx_data    <= '0;
      result_hi  <= '0;
      is_read    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      cmd_err  <= 1'b0;

      if (timeout_hit) begin
        state      <= ST_IDLE;
        cmd_err    <= 1'b1;
        alu_clk_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_valid) begin
              case (bus.rx_data[7:0])
                CMD_WR:      state <= ST_WR_ADDR;
                CMD_RD:      state <= ST_RD_ADDR;
                CMD_ALU_OP:  state <= ST_OP_A;
                CMD_ALU_NOP: begin
                  state      <= ST_ALU_FUN;
                  alu_clk_en <= 1'b1;
                end
                default:     cmd_err <= 1'b1;
              endcase
            end
          end

          ST_WR_ADDR: begin
            if (bus.rx_valid) begin
              rf_addr <= bus.rx_data[ADDR_W-1:0];
              state   <= ST_WR_DATA;
            end
          end

          ST_WR_DATA: begin
            if (bus.rx_valid) begin
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              state      <= ST_IDLE;
            end
          end

          ST_RD_ADDR: begin
            if (bus.rx_valid) begin
              rf_addr  <= bus.rx_data[ADDR_W-1:0];
              rf_rd_en <= 1'b1;
              state    <= ST_RD_WAIT;
            end
          end

          ST_RD_WAIT: begin
            if (bus.rf_rd_valid) begin
              tx_data <= bus.rf_rd_data;
              is_read <= 1'b1;
              state   <= ST_TX_LO;
            end
          end

          ST_OP_A: begin
            if (bus.rx_valid) begin
              rf_addr    <= ADDR_W'(REG0_ADDR);
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              state      <= ST_OP_B;
            end
          end

          ST_OP_B: begin
            if (bus.rx_valid) begin
              rf_addr    <= ADDR_W'(REG1_ADDR);
              rf_wr_data <= bus.rx_data;
              rf_wr_en   <= 1'b1;
              alu_clk_en <= 1'b1;
              state      <= ST_ALU_FUN;
            end
          end

          ST_ALU_FUN: begin
            if (bus.rx_valid) begin
              alu_fun <= bus.rx_data[3:0];
              alu_en  <= 1'b1;
              state   <= ST_ALU_WAIT;
            end
          end

          ST_ALU_WAIT: begin
            if (bus.alu_out_valid) begin
              alu_en     <= 1'b0;
              alu_clk_en <= 1'b0;
              tx_data    <= bus.alu_out[DATA_W-1:0];
              result_hi  <= bus.alu_out[2*DATA_W-1:DATA_W];
              is_read    <= 1'b0;
              state      <= ST_TX_LO;
            end
          end

          ST_TX_LO: begin
            if (!bus.tx_full) begin
              if (is_read) begin
                state <= ST_IDLE;
              end else begin
                tx_data <= result_hi;
                state   <= ST_TX_HI;
              end
            end
          end

          ST_TX_HI: begin
            if (!bus.tx_full) begin
              state <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
